// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit front end between execute stage and a
// word-organised data memory.
//
// One request at a time: IDLE accepts, EXEC performs the single memory
// access (sub-word stores are read-merge-write on the same word), RESP holds
// the registered response until the consumer takes it.
//
// Optional feature macro: LSU_BYPASS_EN
//   defined   -> a new request may be accepted in RESP on the response
//                handshake edge, going straight RESP->EXEC.
//   undefined -> requests are accepted only in IDLE.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_*              request handshake (valid/ready, we, size, unsigned,
//                      addr, wdata)
//   resp_*             response handshake (valid/ready, rdata, err)
//   mem_req_o/mem_we_o memory access / write enable (EXEC only)
//   mem_waddr_o        word-aligned write address
//   mem_wdata_o        merged word to write
//   mem_raddr_o        word-aligned read address
//   mem_rdata_i        combinational read data for mem_raddr_o
// ---------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] mem_raddr_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_valid;

  logic        w_err;
  logic        w_exec;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Misaligned or illegal-size request detection on the registered request.
  always_comb begin
    case (r_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = (r_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    w_byte = mem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    w_half = mem_rdata_i[{r_addr[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_rdata_i;
    endcase
  end

  // Store merge: replace the addressed little-endian lane of the read word.
  always_comb begin
    w_merge = mem_rdata_i;
    case (r_size)
      2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      2'b10:   w_merge = r_wdata;
      default: w_merge = mem_rdata_i;
    endcase
  end

  // rst is folded in so a reset raised mid-EXEC kills the write before the
  // next edge rather than after it.
  assign w_exec      = (r_state == S_EXEC) && !rst;
  assign mem_req_o   = w_exec && !w_err;
  assign mem_we_o    = mem_req_o && r_we;
  assign mem_waddr_o = {r_addr[31:2], 2'b00};
  assign mem_raddr_o = {r_addr[31:2], 2'b00};
  assign mem_wdata_o = (r_state == S_EXEC) ? w_merge : r_wdata;

`ifdef LSU_BYPASS_EN
  assign req_ready_o = !rst && ((r_state == S_IDLE) ||
                                ((r_state == S_RESP) && resp_ready_i));
`else
  assign req_ready_o = !rst && (r_state == S_IDLE);
`endif

  assign resp_valid_o = r_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

  // Control FSM with registered request capture and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_rdata    <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we       <= req_we_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_err   <= w_err;
          r_rdata <= (w_err || r_we) ? 32'h0000_0000 : w_load;
          r_valid <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            r_valid <= 1'b0;
`ifdef LSU_BYPASS_EN
            if (req_valid_i) begin
              r_we       <= req_we_i;
              r_size     <= req_size_i;
              r_unsigned <= req_unsigned_i;
              r_addr     <= req_addr_i;
              r_wdata    <= req_wdata_i;
              r_state    <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
`else
            r_state <= S_IDLE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small word memory model.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  // memory model: 64 words, preload port plus DUT write port
  logic [31:0] mem [0:63];
  logic        init_we;
  logic [5:0]  init_idx;
  logic [31:0] init_val;
  int          we_cnt  = 0;
  int          req_cnt = 0;

  lsu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_raddr_o    (mem_raddr_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_raddr_o[7:2]];

  always @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_val;
    else if (mem_we_o) mem[mem_waddr_o[7:2]] <= mem_wdata_o;
    if (mem_we_o) we_cnt <= we_cnt + 1;
    if (mem_req_o) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    init_we  = 1'b1;
    init_idx = addr[7:2];
    init_val = val;
    @(negedge clk);
    init_we  = 1'b0;
  endtask

  // One full transaction starting on a negedge; checks EXEC and RESP cycles.
  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_req, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int n;
    int we0;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wd;
    we0 = we_cnt;
    @(negedge clk);  // EXEC
    req_valid_i = 1'b0;
    chk({tag, "_mreq"}, {31'd0, mem_req_o}, {31'd0, exp_req});
    chk({tag, "_mwe"}, {31'd0, mem_we_o}, {31'd0, exp_req & we});
    if (exp_req && we) chk({tag, "_mwdata"}, mem_wdata_o, exp_wd);
    if (exp_req) chk({tag, "_raddr"}, mem_raddr_o, {addr[31:2], 2'b00});
    @(negedge clk);  // RESP
    chk({tag, "_we_cycles"}, we_cnt - we0, (exp_req && we) ? 32'd1 : 32'd0);
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_valid"}, {31'd0, resp_valid_o}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata_o, exp_rd);
      chk({tag, "_err"}, {31'd0, resp_err_o}, {31'd0, exp_err});
      if (i < stall) begin
        chk({tag, "_bp_ready"}, {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
      end
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  initial begin
    int rc0;
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    resp_ready_i = 1'b0; init_we = 1'b0; init_idx = 6'd0; init_val = 32'h0;
    @(negedge clk);
    preload(32'h10, 32'h8899AABB);
    preload(32'h20, 32'h11223344);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err", {31'd0, resp_err_o}, 32'd0);
    chk("rst_mreq", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mwe", {31'd0, mem_we_o}, 32'd0);
    chk("rst_waddr", mem_waddr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);

    // loads
    run_req("ldw",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 32'h8899AABB, 1'b0, 0);
    run_req("ldb_s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 32'hFFFFFF88, 1'b0, 0);
    run_req("ldb_u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0, 32'h00000088, 1'b0, 0);
    run_req("ldb0u", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0, 32'h000000BB, 1'b0, 0);
    run_req("ldh_s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 32'hFFFF8899, 1'b0, 0);
    run_req("ldh_u", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0, 32'h0000AABB, 1'b0, 0);

    // sub-word stores (read-merge-write)
    run_req("sth",   1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b1, 32'hBEEF3344, 32'h0, 1'b0, 0);
    run_req("ldw2",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 32'hBEEF3344, 1'b0, 0);
    run_req("stb",   1'b1, 2'b00, 1'b0, 32'h21, 32'h123456A5, 1'b1, 32'hBEEFA544, 32'h0, 1'b0, 0);
    chk("stb_mem", mem[8], 32'hBEEFA544);

    // errors: no memory access, memory unchanged
    rc0 = req_cnt;
    run_req("stw_mis", 1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    run_req("ld_ill",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    run_req("ldh_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    chk("err_no_mreq", req_cnt - rc0, 32'd0);
    chk("err_mem", mem[8], 32'hBEEFA544);

    // back-pressure: five stalled RESP cycles
    run_req("bp", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 32'h8899AABB, 1'b0, 5);

`ifdef LSU_BYPASS_EN
    // bypass: new request accepted on the response handshake edge
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h10;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("byp_valid1", {31'd0, resp_valid_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = 32'h20; resp_ready_i = 1'b1;
    #1;
    chk("byp_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0; resp_ready_i = 1'b0;
    chk("byp_exec", {31'd0, mem_req_o}, 32'd1);
    chk("byp_raddr", mem_raddr_o, 32'h20);
    @(negedge clk);
    chk("byp_rdata", resp_rdata_o, 32'hBEEFA544);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
`endif

    // reset during a store's EXEC cycle
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10;
    req_unsigned_i = 1'b0; req_addr_i = 32'h10; req_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rexec_mwe_pre", {31'd0, mem_we_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rexec_mwe", {31'd0, mem_we_o}, 32'd0);
    @(negedge clk);
    chk("rexec_mem", mem[4], 32'h8899AABB);
    chk("rexec_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rexec_rdata", resp_rdata_o, 32'h0);
    chk("rexec_err", {31'd0, resp_err_o}, 32'd0);
    chk("rexec_mreq", {31'd0, mem_req_o}, 32'd0);
    chk("rexec_waddr", mem_waddr_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rexec_ready", {31'd0, req_ready_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
